loop_fetch_sched: RTL
=====================

Name: loop_fetch_sched

Overview:
- Fetch-source scheduler between instruction memory and the loop-buffer (uop cache) FSM in the RISC-V IF stage.
- Decides each cycle whether IF/ID receives the imem instruction, the loop-buffer replay instruction or a NOP bubble.
- Freezes the PC during replay, issues the resume-PC redirect when the loop buffer exits, and squashes wrong-path fetches for a fixed drain window.

Parameters:
- DRAIN_CYCLES, 2: bubble cycles inserted after a redirect; legal range 1..7.
- NOP_INSTR, 32'h00000013: instruction injected as a bubble (addi x0,x0,0).
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- block_signal  input  1  loop buffer is in replay or about to replay
- flush  input  1  loop-buffer exit pulse (replay mispredicted)
- new_pc  input  32  resume PC from the loop buffer, valid when flush=1
- lb_instruction  input  32  loop-buffer replay instruction
- imem_instruction  input  32  instruction-memory fetch data
- bubble_idex  input  1  ID/EX bubble; holds IF/ID
- mispredict  input  1  pipeline branch mispredict (non-replay)
- pc_write  output  1  PC register enable
- pc_redirect  output  1  load redirect_pc into the PC this cycle
- redirect_pc  output  32  redirect target
- if_instruction  output  32  instruction to IF/ID
- if_valid  output  1  if_instruction is real (not a bubble)
- replay_active  output  1  IF/ID is fed from the loop buffer
- replay_cycles  output  CNT_W  statistics, see Optional Feature
- replay_exits  output  CNT_W  statistics, see Optional Feature

Behaviour:
- States are FETCH=0, ARM=1, REPLAY=2, EXIT=3 and DRAIN=4, encoded in a 3-bit register.
- The state register and drain counter are updated on posedge clk or negedge reset. Outputs are combinational from state and inputs.
- Reset forces state=FETCH and drain_cnt=0. Output values while reset is held:
  - pc_write=1, pc_redirect=0, redirect_pc=0
  - if_instruction=NOP_INSTR, if_valid=0, replay_active=0
  - both counters=0
- FETCH:
  - Outputs: if_instruction=imem_instruction, if_valid=1, pc_write=!bubble_idex.
  - block_signal=1 goes to ARM.
  - mispredict=1 (and no block_signal) goes to DRAIN with drain_cnt=DRAIN_CYCLES-1.
  - block_signal takes priority over mispredict.
- ARM:
  - This is the single cycle that covers the 1-cycle BRAM read latency.
  - Outputs: pc_write=0, if_instruction=NOP_INSTR, if_valid=0.
  - Always goes to REPLAY next. If flush is seen here, the next state is EXIT instead.
- REPLAY:
  - Outputs: pc_write=0, if_instruction=lb_instruction, if_valid=1, replay_active=1.
  - flush=1 goes to EXIT and latches new_pc into an internal redirect register on the same edge.
  - block_signal=0 without flush is a protocol error. It is treated as flush with the redirect register unchanged.
  - bubble_idex has no effect on state; the loop buffer holds its own read address.
- EXIT:
  - Outputs: pc_redirect=1, redirect_pc=latched PC, pc_write=1, if_instruction=NOP_INSTR, if_valid=0.
  - Next state is DRAIN with drain_cnt=DRAIN_CYCLES-1.
- DRAIN:
  - Outputs: if_instruction=NOP_INSTR, if_valid=0, pc_write=1.
  - drain_cnt decrements each cycle. When drain_cnt=0 the state goes to FETCH.
  - mispredict in DRAIN reloads drain_cnt to DRAIN_CYCLES-1.
  - block_signal in DRAIN is ignored.
- redirect_pc is 0 whenever pc_redirect=0.
- flush and mispredict in the same cycle: flush wins in ARM and REPLAY; mispredict wins in FETCH.
- An asynchronous reset mid-replay returns to FETCH immediately with no redirect issued.

Optional Feature:
- Macro: LOOP_FETCH_STATS_EN.
- When defined:
  - replay_cycles increments in every REPLAY cycle with if_valid=1 and bubble_idex=0.
  - replay_exits increments on each entry to EXIT.
  - Both counters saturate at all-ones and reset to 0.
- When undefined: both outputs are tied to 0 and no counter flops are synthesised.

Test Plan:
- Reset, then imem_instruction=32'h00500093 with block_signal=0 → if_instruction=32'h00500093, if_valid=1, pc_write=1, state FETCH.
- block_signal rises at cycle 10 → cycle 11 (ARM) if_instruction=32'h00000013, if_valid=0, pc_write=0; cycle 12 onward if_instruction=lb_instruction, replay_active=1.
- In REPLAY, flush=1 with new_pc=32'h00000140 → next cycle pc_redirect=1, redirect_pc=32'h00000140; then 2 bubble cycles; then FETCH.
- FETCH with mispredict=1 → 2 NOP cycles, if_valid=0 and no pc_redirect; a second mispredict in the first DRAIN cycle extends the window by 1 cycle.
- Assert reset low during REPLAY → all outputs at reset values within the same cycle; release → FETCH with pc_write=1.
- LOOP_FETCH_STATS_EN defined: 20 REPLAY cycles including 3 with bubble_idex=1, then flush → replay_cycles=17, replay_exits=1. Undefined: both counters read 0.

Source files
------------

// File: rtl/loop_fetch_sched.sv
// loop_fetch_sched
// Chooses the IF/ID instruction source each cycle: instruction memory, the
// loop-buffer replay path, or a NOP bubble. It freezes the PC while the loop
// buffer replays, issues the resume-PC redirect when replay ends, and squashes
// wrong-path fetches for a short drain window after any redirect.
//
// Optional build macro: LOOP_FETCH_STATS_EN enables the replay statistics
// counters. Without it, replay_cycles and replay_exits are tied to zero.
//
// Ports:
//   clk, reset (async, active-low)
//   block_signal, flush, new_pc, lb_instruction  - loop-buffer interface
//   imem_instruction                             - instruction-memory data
//   bubble_idex, mispredict                      - pipeline hazards
//   pc_write, pc_redirect, redirect_pc           - PC control
//   if_instruction, if_valid, replay_active      - IF/ID feed
//   replay_cycles, replay_exits                  - statistics
module loop_fetch_sched #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter logic [31:0] NOP_INSTR    = 32'h00000013,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             block_signal,
    input  logic             flush,
    input  logic [31:0]      new_pc,
    input  logic [31:0]      lb_instruction,
    input  logic [31:0]      imem_instruction,
    input  logic             bubble_idex,
    input  logic             mispredict,
    output logic             pc_write,
    output logic             pc_redirect,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      if_instruction,
    output logic             if_valid,
    output logic             replay_active,
    output logic [CNT_W-1:0] replay_cycles,
    output logic [CNT_W-1:0] replay_exits
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StArm    = 3'd1,
        StReplay = 3'd2,
        StExit   = 3'd3,
        StDrain  = 3'd4
    } state_e;

    localparam logic [2:0] DrainLoad = 3'(DRAIN_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  drain_q, drain_d;
    logic [31:0] redirect_q, redirect_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StFetch;
            drain_q    <= 3'd0;
            redirect_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            redirect_q <= redirect_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        redirect_d = redirect_q;
        unique case (state_q)
            StFetch: begin
                if (block_signal) begin
                    state_d = StArm;
                end else if (mispredict) begin
                    state_d = StDrain;
                    drain_d = DrainLoad;
                end
            end
            StArm: begin
                if (flush) begin
                    state_d    = StExit;
                    redirect_d = new_pc;
                end else begin
                    state_d = StReplay;
                end
            end
            StReplay: begin
                if (flush) begin
                    state_d    = StExit;
                    redirect_d = new_pc;
                end else if (!block_signal) begin
                    // Replay dropped without a flush: exit to the last known resume PC.
                    state_d = StExit;
                end
            end
            StExit: begin
                state_d = StDrain;
                drain_d = DrainLoad;
            end
            StDrain: begin
                if (mispredict) begin
                    drain_d = DrainLoad;
                end else if (drain_q == 3'd0) begin
                    state_d = StFetch;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        pc_write       = 1'b1;
        pc_redirect    = 1'b0;
        redirect_pc    = 32'd0;
        if_instruction = NOP_INSTR;
        if_valid       = 1'b0;
        replay_active  = 1'b0;
        unique case (state_q)
            StFetch: begin
                if_instruction = imem_instruction;
                if_valid       = 1'b1;
                pc_write       = !bubble_idex;
            end
            StArm: begin
                pc_write = 1'b0;
            end
            StReplay: begin
                pc_write       = 1'b0;
                if_instruction = lb_instruction;
                if_valid       = 1'b1;
                replay_active  = 1'b1;
            end
            StExit: begin
                pc_redirect = 1'b1;
                redirect_pc = redirect_q;
            end
            default: ;
        endcase
        // Outputs must show reset values while reset is held, not the FETCH view.
        if (!reset) begin
            pc_write       = 1'b1;
            pc_redirect    = 1'b0;
            redirect_pc    = 32'd0;
            if_instruction = NOP_INSTR;
            if_valid       = 1'b0;
            replay_active  = 1'b0;
        end
    end

`ifdef LOOP_FETCH_STATS_EN
    logic [CNT_W-1:0] replay_cycles_q, replay_exits_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            replay_cycles_q <= '0;
            replay_exits_q  <= '0;
        end else begin
            if (replay_active && if_valid && !bubble_idex && (replay_cycles_q != '1)) begin
                replay_cycles_q <= replay_cycles_q + 1'b1;
            end
            if ((state_d == StExit) && (state_q != StExit) && (replay_exits_q != '1)) begin
                replay_exits_q <= replay_exits_q + 1'b1;
            end
        end
    end

    assign replay_cycles = replay_cycles_q;
    assign replay_exits  = replay_exits_q;
`else
    assign replay_cycles = '0;
    assign replay_exits  = '0;
`endif

endmodule
